// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM state type and synchronizer depth for the SPI register-file slave.
package spi_regfile_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } state_t;

endpackage

// File: rtl/spi_regfile_slave_if.sv
// spi_regfile_slave_if: the four SPI pins between a master and the register-file slave.
interface spi_regfile_slave_if;

    logic spi_ssn_i;
    logic spi_clk_i;
    logic spi_di_i;
    logic spi_do_o;

    modport master (
        output spi_ssn_i,
        output spi_clk_i,
        output spi_di_i,
        input  spi_do_o
    );

    modport slave (
        input  spi_ssn_i,
        input  spi_clk_i,
        input  spi_di_i,
        output spi_do_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings an asynchronous pin into clk_i and flags its rising and falling edges,
// three clk_i cycles after the pin moves.
module spi_sync_edge
    import spi_regfile_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-0 slave with a command word (R/W bit + address) followed by data words
// into a register file that also has a local parallel port. Define SPI_REGFILE_AUTOINC_EN to auto-increment.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int BYTE_SIZE  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spi_regfile_slave_if.slave    spi,
    input  logic [ADDR_WIDTH-1:0] loc_addr_i,
    input  logic [BYTE_SIZE-1:0]  loc_data_i,
    input  logic                  loc_we_i,
    output logic [BYTE_SIZE-1:0]  loc_data_o,
    output logic                  wr_strobe_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  frame_done_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (BYTE_SIZE > 2) ? $clog2(BYTE_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_SIZE - 1);

    state_t state, next_state;

    logic ssn_level, ssn_rise, ssn_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] di_sync;
    logic [SYNC_STAGES:0]   flush;
    logic                   armed;

    logic [BYTE_SIZE-1:0]  regs [DEPTH];
    logic [CNT_W-1:0]      bit_cnt;
    logic [BYTE_SIZE-1:0]  rx_shift, rx_next, tx_shift;
    logic [ADDR_WIDTH-1:0] pointer, pointer_inc, cmd_addr;
    logic                  word_done, frame_start, frame_end, do_bit;
    logic                  wr_strobe, frame_done;
    logic [ADDR_WIDTH-1:0] wr_addr;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ssn_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pin   (spi.spi_ssn_i),
        .level (ssn_level),
        .rise  (ssn_rise),
        .fall  (ssn_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .pin   (spi.spi_clk_i),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    assign rx_next   = {rx_shift[BYTE_SIZE-2:0], di_sync[SYNC_STAGES-1]};
    assign cmd_addr  = rx_next[ADDR_WIDTH-1:0];
    assign word_done = (bit_cnt == LAST_BIT);

`ifdef SPI_REGFILE_AUTOINC_EN
    assign pointer_inc = pointer + ADDR_WIDTH'(1);
`else
    assign pointer_inc = pointer;
`endif

    // A frame only starts once SSN has been seen high after reset; a release with SSN still low
    // otherwise looks like a fresh falling edge. Mode 0 also needs SCLK idle low at frame start.
    assign frame_start = (state == IDLE) && ssn_fall && armed && !sclk_level;
    assign frame_end   = (state != IDLE) && ssn_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = CMD;
        end else if (frame_end) begin
            next_state = IDLE;
        end else if (state == CMD && sclk_rise && word_done) begin
            next_state = rx_next[BYTE_SIZE-1] ? RDATA : WDATA;
        end
    end

    always_comb begin
        do_bit = 1'b0;
        if (state == RDATA) begin
            do_bit = tx_shift[BYTE_SIZE-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the register file is cleared by reset like any other state, so it stays in
            // this clocked block rather than becoming a reset-less RAM.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            di_sync    <= '0;
            flush      <= '0;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            pointer    <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            di_sync    <= {di_sync[SYNC_STAGES-2:0], spi.spi_di_i};
            flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
            armed      <= armed | (flush[SYNC_STAGES] & ssn_level);
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;

            // NOTE: the SPI write below is issued later in this block, so on an address clash its
            // non-blocking update is the one that lands.
            if (loc_we_i) begin
                regs[loc_addr_i] <= loc_data_i;
            end

            if (frame_start) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (frame_end) begin
                frame_done <= 1'b1;
            end else if (state != IDLE && sclk_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
                if (word_done) begin
                    case (state)
                        CMD: begin
                            pointer <= cmd_addr;
                            if (rx_next[BYTE_SIZE-1]) begin
                                tx_shift <= regs[cmd_addr];
                            end
                        end
                        WDATA: begin
                            regs[pointer] <= rx_next;
                            wr_strobe     <= 1'b1;
                            wr_addr       <= pointer;
                            pointer       <= pointer_inc;
                        end
                        RDATA: begin
                            pointer  <= pointer_inc;
                            tx_shift <= regs[pointer_inc];
                        end
                        default: ;
                    endcase
                end
            end else if (state == RDATA && sclk_fall && bit_cnt != '0) begin
                // The falling edge right after a word boundary keeps the freshly loaded MSB on MISO.
                tx_shift <= {tx_shift[BYTE_SIZE-2:0], 1'b0};
            end
        end
    end

    assign spi.spi_do_o = do_bit;
    assign loc_data_o   = regs[loc_addr_i];
    assign wr_strobe_o  = wr_strobe;
    assign wr_addr_o    = wr_addr;
    assign frame_done_o = frame_done;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb_spi_regfile_slave: SPI master stimulus with a register-array reference model; monitors
// compare write strobes, MISO bytes and frame_done pulses against scoreboard queues.
`timescale 1ns/1ps
module tb_spi_regfile_slave;
    import spi_regfile_pkg::*;

    localparam int BS    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int HALF  = 5;  // clk cycles per 200 ns SCLK half period

`ifdef SPI_REGFILE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BS-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] loc_addr;
    logic [BS-1:0] loc_data;
    logic          loc_we;
    logic [BS-1:0] loc_rdata;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;

    wr_t          exp_wr[$];
    logic [BS-1:0] exp_miso[$];
    int           exp_done = 0;
    logic [BS-1:0] model[DEPTH];
    logic [BS-1:0] frame_buf[8];

    always #20 clk = ~clk;

    spi_regfile_slave_if spi ();

    spi_regfile_slave #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi          (spi),
        .loc_addr_i   (loc_addr),
        .loc_data_i   (loc_data),
        .loc_we_i     (loc_we),
        .loc_data_o   (loc_rdata),
        .wr_strobe_o  (wr_strobe),
        .wr_addr_o    (wr_addr),
        .frame_done_o (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write strobe and frame_done monitor
    initial begin : wr_mon
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                check("wr_strobe_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr_o", wr_addr, e.addr);
                    check("wr_data", dut.regs[wr_addr], e.data);
                end
            end
            if (frame_done === 1'b1) begin
                check("frame_done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // MISO monitor: samples on SCLK rise like the master, one byte per BS complete bits
    initial begin : miso_mon
        logic [BS-1:0] cur;
        logic [BS-1:0] want;
        int nb;
        nb = 0;
        cur = '0;
        forever begin
            @(posedge spi.spi_clk_i or posedge spi.spi_ssn_i);
            if (spi.spi_ssn_i === 1'b1) begin
                nb = 0;
            end else begin
                cur = {cur[BS-2:0], spi.spi_do_o};
                nb++;
                if (nb == BS) begin
                    nb = 0;
                    check("miso_expected", exp_miso.size() > 0, 1);
                    if (exp_miso.size() > 0) begin
                        want = exp_miso.pop_front();
                        check("miso_byte", cur, want);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        spi.spi_di_i = b;
        wait_clk(HALF);
        spi.spi_clk_i = 1'b1;
        wait_clk(HALF);
        spi.spi_clk_i = 1'b0;
    endtask

    // Sends frame_buf[0..nbytes-1] plus extra_bits of frame_buf[nbytes]; optional reset mid-frame.
    task automatic do_frame(input int nbytes, input int extra_bits, input bit rst_mid);
        logic [BS-1:0] cmd;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [BS-1:0] cur;
        wr_t w;
        bit rd;
        cmd  = frame_buf[0];
        rd   = cmd[BS-1];
        base = cmd[AW-1:0];
        @(negedge clk);
        spi.spi_ssn_i = 1'b0;
        wait_clk(HALF);
        exp_miso.push_back('0);
        for (int b = BS - 1; b >= 0; b--) send_bit(cmd[b]);
        for (int k = 1; k < nbytes; k++) begin
            a   = base + (AUTOINC ? AW'(k - 1) : AW'(0));
            cur = frame_buf[k];
            if (rd) begin
                exp_miso.push_back(model[a]);
            end else begin
                exp_miso.push_back('0);
                w.addr = a;
                w.data = cur;
                exp_wr.push_back(w);
                model[a] = cur;
            end
            for (int b = BS - 1; b >= 0; b--) send_bit(cur[b]);
        end
        cur = frame_buf[nbytes];
        for (int b = 0; b < extra_bits; b++) send_bit(cur[BS-1-b]);
        wait_clk(HALF);
        if (rst_mid) begin
            rst = 1'b1;
            wait_clk(2);
            check("do_in_reset", spi.spi_do_o, 0);
            check("state_in_reset", dut.state, IDLE);
            rst = 1'b0;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            wait_clk(6);
            check("do_after_reset", spi.spi_do_o, 0);
            check("state_after_reset", dut.state, IDLE);
        end else begin
            exp_done++;
        end
        spi.spi_ssn_i = 1'b1;
        wait_clk(4 * HALF);
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [BS-1:0] d);
        @(negedge clk);
        loc_addr = a;
        loc_data = d;
        loc_we   = 1'b1;
        @(negedge clk);
        loc_we   = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_check(input string name, input logic [AW-1:0] a, input logic [BS-1:0] exp);
        @(negedge clk);
        loc_addr = a;
        #2;
        check(name, loc_rdata, exp);
    endtask

    // SPI write of one word with a local write landing in the very cycle the SPI write commits
    task automatic collide(input logic [AW-1:0] sa, input logic [BS-1:0] sd,
                           input logic [AW-1:0] la, input logic [BS-1:0] ld);
        frame_buf[0] = {4'h0, sa};
        frame_buf[1] = sd;
        fork
            do_frame(2, 0, 1'b0);
            begin
                repeat (2 * BS) @(posedge spi.spi_clk_i);
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                loc_addr = la;
                loc_data = ld;
                loc_we   = 1'b1;
                @(negedge clk);
                loc_we   = 1'b0;
                if (la != sa) model[la] = ld;
            end
        join
    endtask

    initial begin : main
        logic [BS-1:0] prev0;
        logic [BS-1:0] prev7;
        int nb;
        spi.spi_ssn_i = 1'b1;
        spi.spi_clk_i = 1'b0;
        spi.spi_di_i  = 1'b0;
        loc_we   = 1'b0;
        loc_addr = '0;
        loc_data = '0;
        rst      = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        wait_clk(5);
        check("reset_do", spi.spi_do_o, 0);
        check("reset_wr_strobe", wr_strobe, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_state", dut.state, IDLE);
        rst = 1'b0;
        wait_clk(10);
        for (int i = 0; i < 4; i++) loc_check("reset_reg", AW'(i * 5), 8'h00);

        // Basic write
        frame_buf[0] = 8'h05;
        frame_buf[1] = 8'h3C;
        do_frame(2, 0, 1'b0);
        loc_check("reg5_written", 4'd5, 8'h3C);

        // Read of a locally preloaded register
        loc_write(4'd2, 8'hA1);
        frame_buf[0] = 8'h82;
        frame_buf[1] = 8'h00;
        do_frame(2, 0, 1'b0);

        // Multi-word write at the top address
        prev0 = model[0];
        frame_buf[0] = 8'h0F;
        frame_buf[1] = 8'h11;
        frame_buf[2] = 8'h22;
        do_frame(3, 0, 1'b0);
        loc_check("reg15_multi", 4'd15, AUTOINC ? 8'h11 : 8'h22);
        loc_check("reg0_multi", 4'd0, AUTOINC ? 8'h22 : prev0);

        // Write aborted after 4 data bits
        prev7 = model[7];
        frame_buf[0] = 8'h07;
        frame_buf[1] = 8'hF0;
        do_frame(1, 4, 1'b0);
        check("state_after_abort", dut.state, IDLE);
        loc_check("reg7_after_abort", 4'd7, prev7);

        // Same-cycle local and SPI writes
        collide(4'd3, 8'hAA, 4'd3, 8'h55);
        loc_check("reg3_spi_wins", 4'd3, 8'hAA);
        collide(4'd6, 8'h5A, 4'd9, 8'hC3);
        loc_check("reg6_both", 4'd6, 8'h5A);
        loc_check("reg9_both", 4'd9, 8'hC3);

        // Reset in the middle of reading reg[2], then normal traffic
        frame_buf[0] = 8'h82;
        frame_buf[1] = 8'h00;
        do_frame(1, 3, 1'b1);
        loc_check("reg2_cleared", 4'd2, 8'h00);
        frame_buf[0] = 8'h04;
        frame_buf[1] = 8'h77;
        do_frame(2, 0, 1'b0);
        frame_buf[0] = 8'h84;
        frame_buf[1] = 8'h00;
        do_frame(2, 0, 1'b0);

        // Randomized frames and local writes
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(2) == 0) loc_write(AW'($urandom_range(15)), BS'($urandom_range(255)));
            nb = $urandom_range(3) + 2;
            frame_buf[0] = BS'($urandom);
            for (int k = 1; k < nb; k++) frame_buf[k] = BS'($urandom);
            do_frame(nb, 0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) loc_check("final_reg", AW'(i), model[i]);

        wait_clk(20);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_miso", exp_miso.size(), 0);
        check("pending_frame_done", exp_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_regfile_slave.md
SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

Interface
REQ-001 Parameter BYTE_SIZE, default 8: SPI word width in bits; the command and data words are both BYTE_SIZE bits.
REQ-002 Parameter ADDR_WIDTH, default 4: register file holds 2**ADDR_WIDTH registers of BYTE_SIZE bits each.
REQ-003 clk_i  input  1  single system clock; all logic is clocked on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 spi_ssn_i  input  1  SPI slave select, active low, asynchronous to clk_i.
REQ-006 spi_clk_i  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk_i.
REQ-007 spi_di_i  input  1  MOSI, MSB first.
REQ-008 spi_do_o  output  1  MISO, MSB first; driven to 0 whenever the block is not in RDATA.
REQ-009 loc_addr_i  input  ADDR_WIDTH  local-port register address.
REQ-010 loc_data_i  input  BYTE_SIZE  local-port write data.
REQ-011 loc_we_i  input  1  local-port write enable.
REQ-012 loc_data_o  output  BYTE_SIZE  combinational read of reg[loc_addr_i].
REQ-013 wr_strobe_o  output  1  one-cycle pulse on each SPI register write.
REQ-014 wr_addr_o  output  ADDR_WIDTH  address of the current or last SPI write.
REQ-015 frame_done_o  output  1  one-cycle pulse when spi_ssn_i deasserts after an active frame.

Function
REQ-016 spi_ssn_i, spi_clk_i and spi_di_i shall each pass through a 2-flop synchronizer; SCLK and SSN edges are detected on synchronized values with one extra register (3-cycle latency from pin).
REQ-017 The block shall require an SCLK half-period of at least 4 clk_i periods; behaviour at faster SCLK is unspecified.
REQ-018 FSM states: IDLE, CMD, WDATA, RDATA.
REQ-019 A synchronized SSN falling edge shall move IDLE->CMD and clear the bit counter.
REQ-020 Each synchronized SCLK rising edge shall shift spi_di_i into the RX shift register and increment the bit counter; the counter wraps at BYTE_SIZE.
REQ-021 At the end of the CMD word: bit[BYTE_SIZE-1] = 1 selects RDATA and 0 selects WDATA; the low ADDR_WIDTH bits load the address pointer; remaining bits are ignored.
REQ-022 On entry to RDATA and after each completed read word, the TX shift register shall load reg[pointer], and spi_do_o shall present its MSB in the same cycle.
REQ-023 Each synchronized SCLK falling edge in RDATA shall shift TX left, with spi_do_o updated on that cycle.
REQ-024 WDATA: on each completed word, reg[pointer] <= RX word, wr_strobe_o=1 for one cycle, and wr_addr_o=pointer.
REQ-025 An SPI write and loc_we_i in the same cycle to the same address: the SPI write wins; different addresses: both take effect.
REQ-026 A synchronized SSN rising edge in any non-IDLE state shall go to IDLE, discard any partial word without a write, and pulse frame_done_o for one cycle.

Reset
REQ-027 While rst_i is high: state=IDLE, all registers=0, shift registers and counters=0, spi_do_o=0, wr_strobe_o=0, wr_addr_o=0, frame_done_o=0, synchronizers=idle values (SSN=1, SCLK=0).
REQ-028 Reset asserted mid-frame shall abort the frame with no write; after release the block waits for a fresh SSN falling edge.

Configuration
REQ-029 Macro SPI_REGFILE_AUTOINC_EN defined: after each data word the pointer shall increment, wrapping from 2**ADDR_WIDTH-1 to 0.
REQ-030 Macro undefined: the pointer shall stay fixed, so every data word in a frame accesses the command address.

Structure
REQ-031 Package spi_regfile_pkg shall hold the FSM state enum typedef and the SYNC_STAGES=2 constant.
REQ-032 Sub-module spi_sync_edge (2-flop synchronizer plus rise/fall detect) shall be instantiated once each for SSN and SCLK; MOSI uses a plain synchronizer.

Verification
REQ-033 clk 25 MHz, SCLK half-period 200 ns, frame 0x05,0x3C -> reg[5]=0x3C, one wr_strobe_o pulse with wr_addr_o=5, frame_done_o pulse after SSN high.
REQ-034 With reg[2]=0xA1 preloaded via the local port, frame 0x82 plus 8 dummy clocks -> MISO bits 1,0,1,0,0,0,0,1.
REQ-035 AUTOINC_EN, frame 0x0F,0x11,0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap); without the macro -> reg[15]=0x22.
REQ-036 SSN raised after 4 data bits of a write -> no wr_strobe_o, target register unchanged, state IDLE.
REQ-037 loc_we_i to addr 3 with data 0x55 in the same cycle as an SPI write of 0xAA to addr 3 -> reg[3]=0xAA.
REQ-038 rst_i pulsed mid-read -> spi_do_o=0 and state IDLE; the next full frame works normally.
